// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The state encoding is fixed at 3 bits so checkers can bind to it directly.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear restarts the period so every FSM state begins on a fresh bit boundary.
module baud_tick_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO (1-cycle read latency)
// and sends them back-to-back while enable is high; frames are never truncated.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] sent_cnt
);

    state_t     state, state_next;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_idx, bit_next;
    logic       tx_next;
    logic       tick;
    logic       clear;
    logic       frame_done;

    // Any state change restarts the bit period.
    assign clear = (state_next != state);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    assign fifo_rd_en = (state == POP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        shift_next = shift;
        bit_next   = bit_idx;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) state_next = POP;
            end
            POP:  state_next = LOAD;
            LOAD: begin
                shift_next = fifo_dout;
                state_next = START;
            end
            START: begin
                if (tick) begin
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    state_next = (enable && !fifo_empty) ? POP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the value the next state will present.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            sent_cnt <= '0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_next;
            tx      <= tx_next;
            if (frame_done) sent_cnt <= sent_cnt + 16'd1;
        end
    end

endmodule
